// File: rtl/vu_meter_bar.sv
// -----------------------------------------------------------------------------
// vu_meter_bar
//   N-LED bar-graph level meter for the sampler path. Sample buffers are
//   drained through the buffer_ready/read_enable/read_ack handshake. Each
//   accepted sample is rectified and fed into a leaky integrator. A slow
//   display tick turns the integrator value into a log-spaced bar, with
//   6 dB (one doubling of threshold) per LED.
//
//   Optional feature, selected by the macro VU_METER_PEAK_HOLD_EN:
//     A falling peak-hold dot. The dot holds for HOLD_TICKS display ticks.
//     After that it drops one LED per tick. With the macro undefined, the
//     LEDs show the plain bar and peak_idx_o is tied to zero.
//
// Ports
//   clk_i           in   system clock
//   rst_ni          in   asynchronous active-low reset
//   buffer_ready_i  in   a full sample buffer is available
//   read_enable_i   in   buffer is streaming, so ram_sample_i is valid
//   ram_sample_i    in   current sample, two's complement
//   read_ack_o      out  registered read acknowledge/request
//   leds_o          out  bar (plus peak dot), LED0 = lowest
//   level_o         out  current integrator value
//   peak_idx_o      out  peak dot position, 1-based (0 = no dot)
// -----------------------------------------------------------------------------
module vu_meter_bar #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int NUM_LEDS     = 8,
  parameter int LEVEL_WIDTH  = 32,
  parameter int DECAY_SHIFT  = 11,
  parameter int SCALE_SHIFT  = 2,
  parameter int TH_BASE      = 100,
  parameter int LED_DIV      = 540000,
  parameter int HOLD_TICKS   = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             buffer_ready_i,
  input  logic                             read_enable_i,
  input  logic signed [SAMPLE_WIDTH-1:0]   ram_sample_i,
  output logic                             read_ack_o,
  output logic [NUM_LEDS-1:0]              leds_o,
  output logic [LEVEL_WIDTH-1:0]           level_o,
  output logic [$clog2(NUM_LEDS+1)-1:0]    peak_idx_o
);

  localparam int IDX_W = $clog2(NUM_LEDS + 1);
  localparam int DIV_W = $clog2(LED_DIV);
  // Threshold scratch width: wide enough to see TH_BASE shifted by up to 15.
  localparam int TH_W  = LEVEL_WIDTH + 48;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(LED_DIV - 1);

  localparam logic signed [SAMPLE_WIDTH-1:0] MOST_NEG = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
  localparam logic        [SAMPLE_WIDTH-1:0] MAX_POS  = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};

  // Reject parameter sets that the bar/divider logic cannot represent.
  if (NUM_LEDS < 1 || NUM_LEDS > 16 || LED_DIV < 2 || HOLD_TICKS < 0) begin : g_cfg_err
    $error("vu_meter_bar: unsupported parameter set");
  end

  // |s|. The most-negative code saturates instead of wrapping back to itself.
  function automatic logic [SAMPLE_WIDTH-1:0] rectify(input logic signed [SAMPLE_WIDTH-1:0] s);
    logic [SAMPLE_WIDTH-1:0] m;
    if (!s[SAMPLE_WIDTH-1]) begin
      m = s;
    end else if (s == MOST_NEG) begin
      m = MAX_POS;
    end else begin
      m = -s;
    end
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // Read handshake FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_WAIT = 2'b10
  } state_t;

  state_t state_r;
  state_t state_s;
  logic   ack_s;
  logic   read_ack_r;
  logic   accept_s;

  // State register and registered acknowledge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= ST_IDLE;
      read_ack_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      read_ack_r <= ack_s;
    end
  end

  // Next state and next acknowledge. The acknowledge is low unless a branch raises it.
  always_comb begin
    state_s = ST_IDLE;
    ack_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (buffer_ready_i) begin
          state_s = ST_READ;
          ack_s   = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (read_enable_i) begin
          state_s = ST_READ;
          ack_s   = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (buffer_ready_i) begin
          state_s = ST_READ;
          ack_s   = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // A sample is taken only while streaming and after the acknowledge is visible.
  assign accept_s = (state_r == ST_READ) && read_enable_i && read_ack_r;

  // ---------------------------------------------------------------------------
  // Leaky integrator
  // ---------------------------------------------------------------------------
  logic [SAMPLE_WIDTH-1:0] mag_s;
  logic [LEVEL_WIDTH-1:0]  scaled_s;
  logic [LEVEL_WIDTH-1:0]  leaked_s;
  logic [LEVEL_WIDTH:0]    sum_s;
  logic [LEVEL_WIDTH-1:0]  level_n_s;
  logic [LEVEL_WIDTH-1:0]  level_r;

  assign mag_s    = rectify(ram_sample_i);
  assign scaled_s = LEVEL_WIDTH'(mag_s) >> SCALE_SHIFT;
  // level - (level>>DECAY_SHIFT) can never underflow.
  assign leaked_s = level_r - (level_r >> DECAY_SHIFT);
  assign sum_s    = {1'b0, leaked_s} + {1'b0, scaled_s};

  // Saturate on carry-out so a loud stream pins the level instead of wrapping.
  always_comb begin
    level_n_s = level_r;
    if (sum_s[LEVEL_WIDTH]) begin
      level_n_s = '1;
    end else begin
      level_n_s = sum_s[LEVEL_WIDTH-1:0];
    end
  end

  // The integrator advances only on an accepted sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_r <= '0;
    end else if (accept_s) begin
      level_r <= level_n_s;
    end else begin
      level_r <= level_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Display tick divider
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_r;
  logic             tick_r;

  // Divider counts 0..LED_DIV-1. The tick pulse is registered, so it lands one cycle after the wrap value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      tick_r <= (div_r == DIV_LAST);
      if (div_r == DIV_LAST) begin
        div_r <= '0;
      end else begin
        div_r <= div_r + DIV_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bar thresholds
  //   The thresholds are elaboration-time constants. A threshold whose
  //   shifted value no longer fits LEVEL_WIDTH can never be exceeded, so
  //   its LED is tied off.
  //   The bar reads level_r, the pre-update value, when an accept
  //   coincides with a tick.
  // ---------------------------------------------------------------------------
  logic [NUM_LEDS-1:0] bar_s;

  for (genvar k = 0; k < NUM_LEDS; k++) begin : g_bar
    localparam logic [TH_W-1:0] TH_K   = TH_W'(TH_BASE) << k;
    localparam bit              TH_OVF = |TH_K[TH_W-1:LEVEL_WIDTH];
    if (TH_OVF) begin : g_never
      assign bar_s[k] = 1'b0;
    end else begin : g_cmp
      assign bar_s[k] = (level_r > TH_K[LEVEL_WIDTH-1:0]);
    end
  end

  logic [NUM_LEDS-1:0] leds_r;

`ifdef VU_METER_PEAK_HOLD_EN
  localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  logic [IDX_W-1:0]  top_s;
  logic [IDX_W-1:0]  peak_r;
  logic [IDX_W-1:0]  peak_n_s;
  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] hold_n_s;

  // LED mask carrying only the peak dot. Position p lights LED p-1, and p = 0 means no dot.
  function automatic logic [NUM_LEDS-1:0] dot_mask(input logic [IDX_W-1:0] p);
    logic [NUM_LEDS-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      m[k] = (p == IDX_W'(k + 1));
    end
    return m;
  endfunction

  // Position of the highest lit LED, 1-based.
  always_comb begin
    top_s = '0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      if (bar_s[k]) begin
        top_s = IDX_W'(k + 1);
      end else begin
        top_s = top_s;
      end
    end
  end

  // Peak-hold step applied on each tick. A new high re-arms the hold.
  // After the hold expires, the dot falls one LED per tick.
  always_comb begin
    peak_n_s = peak_r;
    hold_n_s = hold_r;
    if (top_s >= peak_r) begin
      peak_n_s = top_s;
      hold_n_s = HOLD_W'(HOLD_TICKS);
    end else if (hold_r != '0) begin
      hold_n_s = hold_r - HOLD_W'(1);
    end else if (peak_r != '0) begin
      peak_n_s = peak_r - IDX_W'(1);
    end else begin
      peak_n_s = peak_r;
    end
  end

  // Display registers refresh only on the tick. The dot tracks the peak being written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      leds_r <= '0;
      peak_r <= '0;
      hold_r <= '0;
    end else if (tick_r) begin
      leds_r <= bar_s | dot_mask(peak_n_s);
      peak_r <= peak_n_s;
      hold_r <= hold_n_s;
    end else begin
      leds_r <= leds_r;
      peak_r <= peak_r;
      hold_r <= hold_r;
    end
  end

  assign peak_idx_o = peak_r;
`else
  // Display register refreshes only on the tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      leds_r <= '0;
    end else if (tick_r) begin
      leds_r <= bar_s;
    end else begin
      leds_r <= leds_r;
    end
  end

  assign peak_idx_o = {IDX_W{1'b0}};
`endif

  assign read_ack_o = read_ack_r;
  assign leds_o     = leds_r;
  assign level_o    = level_r;

endmodule

// File: tb/tb_vu_meter_bar.sv
// -----------------------------------------------------------------------------
// tb_vu_meter_bar
//   Self-checking bench for vu_meter_bar.
//   Each cycle, a cycle-level reference model predicts the outputs from the
//   driven inputs. The prediction is pushed to a scoreboard queue at the
//   clock edge, then popped and compared at the following falling edge.
//   Directed checks against fixed values cover reset, the first accepts,
//   saturation, bar thresholds and peak fall-off.
//   The peak-hold expectations follow VU_METER_PEAK_HOLD_EN.
// -----------------------------------------------------------------------------
module tb_vu_meter_bar;

  logic               clk_i;
  logic               rst_ni;
  logic               buffer_ready_i;
  logic               read_enable_i;
  logic signed [15:0] ram_sample_i;
  logic               read_ack_o;
  logic [7:0]         leds_o;
  logic [31:0]        level_o;
  logic [3:0]         peak_idx_o;

  vu_meter_bar #(
    .SAMPLE_WIDTH (16),
    .NUM_LEDS     (8),
    .LEVEL_WIDTH  (32),
    .DECAY_SHIFT  (4),
    .SCALE_SHIFT  (0),
    .TH_BASE      (100),
    .LED_DIV      (4),
    .HOLD_TICKS   (2)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .buffer_ready_i (buffer_ready_i),
    .read_enable_i  (read_enable_i),
    .ram_sample_i   (ram_sample_i),
    .read_ack_o     (read_ack_o),
    .leds_o         (leds_o),
    .level_o        (level_o),
    .peak_idx_o     (peak_idx_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        ack;
    logic [31:0] level;
    logic [7:0]  leds;
    logic [3:0]  peak;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  int     m_state;   // 0 idle, 1 read, 2 wait
  bit     m_ack;
  longint m_level;
  int     m_div;
  bit     m_tick;
  logic [7:0] m_leds;
  int     m_peak;
  int     m_hold;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_ack   = 1'b0;
    m_level = 0;
    m_div   = 0;
    m_tick  = 1'b0;
    m_leds  = 8'h00;
    m_peak  = 0;
    m_hold  = 0;
  endtask

  // Advances the model by one clock edge, using the inputs as currently driven.
  task automatic model_step();
    bit     acc;
    int     ns;
    bit     na;
    longint nl;
    longint th;
    int     s;
    int     mag;
    int     top;
    logic [7:0] bar;

    acc = (m_state == 1) && read_enable_i && m_ack;
    ns = m_state;
    na = 1'b0;
    case (m_state)
      0: begin if (buffer_ready_i) begin ns = 1; na = 1'b1; end else ns = 0; end
      1: begin if (read_enable_i)  begin ns = 1; na = 1'b1; end else ns = 2; end
      2: begin if (buffer_ready_i) begin ns = 1; na = 1'b1; end else ns = 2; end
      default: ns = 0;
    endcase

    nl = m_level;
    if (acc) begin
      s = ram_sample_i;
      if (s == -32768) mag = 32767;
      else if (s < 0)  mag = -s;
      else             mag = s;
      nl = m_level - (m_level >> 4) + mag;
      if (nl > 64'h0000_0000_FFFF_FFFF) nl = 64'h0000_0000_FFFF_FFFF;
    end

    if (m_tick) begin
      bar = 8'h00;
      top = 0;
      for (int k = 0; k < 8; k++) begin
        th = 100 << k;
        if (th <= 64'h0000_0000_FFFF_FFFF && m_level > th) bar[k] = 1'b1;
      end
      for (int k = 0; k < 8; k++) begin
        if (bar[k]) top = k + 1;
      end
`ifdef VU_METER_PEAK_HOLD_EN
      if (top >= m_peak) begin
        m_peak = top;
        m_hold = 2;
      end else if (m_hold > 0) begin
        m_hold = m_hold - 1;
      end else if (m_peak > 0) begin
        m_peak = m_peak - 1;
      end
      m_leds = bar;
      if (m_peak > 0) m_leds[m_peak-1] = 1'b1;
`else
      m_leds = bar;
`endif
    end

    m_tick  = (m_div == 3);
    m_div   = (m_div == 3) ? 0 : m_div + 1;
    m_state = ns;
    m_ack   = na;
    m_level = nl;
  endtask

  // One clock: the prediction is queued at the rising edge and compared at the falling edge.
  task automatic step();
    exp_t e;
    @(posedge clk_i);
    model_step();
    e.ack   = m_ack;
    e.level = m_level[31:0];
    e.leds  = m_leds;
    e.peak  = 4'(m_peak);
    sb_q.push_back(e);
    @(negedge clk_i);
    e = sb_q.pop_front();
    check_eq("sb_ack",   {63'd0, read_ack_o}, {63'd0, e.ack});
    check_eq("sb_level", {32'd0, level_o},    {32'd0, e.level});
    check_eq("sb_leds",  {56'd0, leds_o},     {56'd0, e.leds});
    check_eq("sb_peak",  {60'd0, peak_idx_o}, {60'd0, e.peak});
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  int ack_cnt;
  int prev_peak;
  int exp_peak;

  initial begin
    rst_ni         = 1'b0;
    buffer_ready_i = 1'b0;
    read_enable_i  = 1'b0;
    ram_sample_i   = 16'sd0;
    model_reset();
    repeat (3) @(negedge clk_i);
    check_eq("rst_ack",   {63'd0, read_ack_o}, 64'd0);
    check_eq("rst_level", {32'd0, level_o},    64'd0);
    check_eq("rst_leds",  {56'd0, leds_o},     64'd0);
    check_eq("rst_peak",  {60'd0, peak_idx_o}, 64'd0);
    rst_ni = 1'b1;

    // First accepts: a ready pulse, then three samples of 1000.
    ack_cnt = 0;
    buffer_ready_i = 1'b1;
    step();
    if (read_ack_o) ack_cnt++;
    buffer_ready_i = 1'b0;
    read_enable_i  = 1'b1;
    ram_sample_i   = 16'sd1000;
    step();
    if (read_ack_o) ack_cnt++;
    check_eq("t2_level_1", {32'd0, level_o}, 64'd1000);
    step();
    if (read_ack_o) ack_cnt++;
    check_eq("t2_level_2", {32'd0, level_o}, 64'd1938);
    step();
    if (read_ack_o) ack_cnt++;
    read_enable_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (read_ack_o) ack_cnt++;
    end
    check_eq("t2_ack_cycles", 64'(ack_cnt), 64'd4);

    // Async reset in the middle of a read with read_enable held high.
    buffer_ready_i = 1'b1;
    step();
    buffer_ready_i = 1'b0;
    read_enable_i  = 1'b1;
    ram_sample_i   = 16'sd500;
    step();
    step();
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("t1_ack",   {63'd0, read_ack_o}, 64'd0);
    check_eq("t1_level", {32'd0, level_o},    64'd0);
    check_eq("t1_leds",  {56'd0, leds_o},     64'd0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    // With no buffer_ready pulse, the FSM sits in IDLE and never acknowledges.
    ack_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (read_ack_o) ack_cnt++;
    end
    check_eq("t1_idle_no_ack", 64'(ack_cnt), 64'd0);
    read_enable_i = 1'b0;

    // Full-scale negative stream: the level saturates below 2^19 and lights every LED.
    do_reset();
    buffer_ready_i = 1'b1;
    step();
    buffer_ready_i = 1'b0;
    read_enable_i  = 1'b1;
    ram_sample_i   = -16'sd32768;
    for (int i = 0; i < 300; i++) step();
    read_enable_i = 1'b0;
    ram_sample_i  = 16'sd0;
    for (int i = 0; i < 10; i++) step();
    check_eq("t3_below_2p19", {63'd0, (level_o < 32'd524288)}, 64'd1);
    check_eq("t3_converged",  {63'd0, (level_o >= 32'd524272)}, 64'd1);
    check_eq("t3_leds",       {56'd0, leds_o}, 64'hFF);

    // Level held at 450: LEDs 0..2 lit and steady between ticks.
    do_reset();
    buffer_ready_i = 1'b1;
    step();
    buffer_ready_i = 1'b0;
    read_enable_i  = 1'b1;
    ram_sample_i   = 16'sd450;
    step();
    read_enable_i  = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check_eq("t4_level", {32'd0, level_o}, 64'd450);
    check_eq("t4_leds",  {56'd0, leds_o},  64'h07);
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("t4_leds_steady", {56'd0, leds_o}, 64'h07);
    end

    // Level 900, then a stream of silence: the bar shrinks and the peak dot holds, then falls.
    do_reset();
    buffer_ready_i = 1'b1;
    step();
    buffer_ready_i = 1'b0;
    read_enable_i  = 1'b1;
    ram_sample_i   = 16'sd900;
    step();
    read_enable_i  = 1'b0;
    for (int i = 0; i < 10; i++) step();
`ifdef VU_METER_PEAK_HOLD_EN
    exp_peak = 4;
`else
    exp_peak = 0;
`endif
    check_eq("t5_leds_900", {56'd0, leds_o},     64'h0F);
    check_eq("t5_peak_900", {60'd0, peak_idx_o}, 64'(exp_peak));
    buffer_ready_i = 1'b1;
    step();
    buffer_ready_i = 1'b0;
    read_enable_i  = 1'b1;
    ram_sample_i   = 16'sd0;
    prev_peak = peak_idx_o;
    for (int i = 0; i < 80; i++) begin
      step();
      if (int'(peak_idx_o) != prev_peak) begin
        check_eq("t5_peak_step", {60'd0, peak_idx_o}, 64'(prev_peak - 1));
        prev_peak = peak_idx_o;
      end
    end
    read_enable_i = 1'b0;
    check_eq("t5_leds_end", {56'd0, leds_o},     64'd0);
    check_eq("t5_peak_end", {60'd0, peak_idx_o}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
